// File: rtl/bnn_pkg.sv
// Shared constants, FSM encoding and tap-lane layout for the BNN window generator.
// Optional input binarization is selected by BNN_WIN_BINARIZE_EN.
package bnn_pkg;

  localparam int K      = 5;
  localparam int DW     = 8;
  localparam int NI0    = 28;
  localparam int NI1    = 12;
  localparam int NI_MAX = 28;
  localparam int CW     = $clog2(NI_MAX);
  localparam int TAP_W  = K * DW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } win_state_e;

  // Sign-magnitude +1 / -1 used when the input stream is binarized.
  localparam logic [DW-1:0] BIN_POS = 8'h01;
  localparam logic [DW-1:0] BIN_NEG = 8'h81;

  // Lane i holds row r-(K-1)+i, so lane 0 (oldest row) sits in the top byte.
  function automatic int lane_lsb(input int i);
    return TAP_W - DW * (i + 1);
  endfunction

endpackage

// File: rtl/bnn_line_buffer.sv
// One feature-map row of storage with a read-before-write port at a single address.
// The read is combinational so the old word can be forwarded down the chain in the same cycle.
module bnn_line_buffer #(
  parameter int DEPTH = bnn_pkg::NI_MAX,
  parameter int DW    = bnn_pkg::DW
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are deliberately not reset; the consumer never sees unwritten words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/bnn_window_gen.sv
// Sliding-window column-slice generator feeding the 5x5 binary convolution engine.
// Define BNN_WIN_BINARIZE_EN to binarize incoming pixels to sign-magnitude +/-1.
module bnn_window_gen #(
  parameter int K      = bnn_pkg::K,
  parameter int DW     = bnn_pkg::DW,
  parameter int NI0    = bnn_pkg::NI0,
  parameter int NI1    = bnn_pkg::NI1,
  parameter int NI_MAX = bnn_pkg::NI_MAX
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      state,
  input  logic [DW-1:0]             din,
  input  logic                      din_valid,
  output logic [K*DW-1:0]           taps,
  output logic                      tvalid,
  output logic [$clog2(NI_MAX)-1:0] tcol,
  output logic                      done,
  output logic                      busy
);

  import bnn_pkg::*;

  localparam int CWL = $clog2(NI_MAX);
  localparam int NB  = K - 1;

  win_state_e      fsm_reg, fsm_next;
  logic [CWL-1:0]  col_reg, col_next;
  logic [CWL-1:0]  row_reg, row_next;
  logic [CWL-1:0]  ni_reg, ni_next;

  logic [K*DW-1:0] taps_reg;
  logic            tvalid_reg;
  logic [CWL-1:0]  tcol_reg;
  logic            done_reg;

  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            frame_last;
  logic [DW-1:0]   pix;
  logic [K*DW-1:0] slice;
  logic [DW-1:0]   lb_rd [NB];
  logic [DW-1:0]   lb_wr [NB];

`ifdef BNN_WIN_BINARIZE_EN
  assign pix = din[DW-1] ? BIN_NEG : BIN_POS;
`else
  assign pix = din;
`endif

  assign col_last   = (col_reg == ni_reg - CWL'(1));
  assign row_last   = (row_reg == ni_reg - CWL'(1));
  assign frame_last = col_last && row_last;

  // Buffer 0 takes the new pixel; each later buffer takes its predecessor's old word.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lb
    if (gi == 0) begin : g_head
      assign lb_wr[gi] = pix;
    end else begin : g_tail
      assign lb_wr[gi] = lb_rd[gi-1];
    end

    bnn_line_buffer #(
      .DEPTH (NI_MAX),
      .DW    (DW)
    ) u_lb (
      .clk     (clk),
      .we      (accept),
      .addr    (col_reg),
      .wr_data (lb_wr[gi]),
      .rd_data (lb_rd[gi])
    );

    assign slice[lane_lsb(gi) +: DW] = lb_rd[NB-1-gi];
  end

  assign slice[lane_lsb(NB) +: DW] = pix;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_reg <= ST_IDLE;
      col_reg <= '0;
      row_reg <= '0;
      ni_reg  <= CWL'(NI0);
    end else begin
      fsm_reg <= fsm_next;
      col_reg <= col_next;
      row_reg <= row_next;
      ni_reg  <= ni_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    col_next = col_reg;
    row_next = row_reg;
    ni_next  = ni_reg;
    accept   = 1'b0;
    case (fsm_reg)
      ST_IDLE: begin
        col_next = '0;
        row_next = '0;
        if (start) begin
          fsm_next = ST_FILL;
          ni_next  = state ? CWL'(NI1) : CWL'(NI0);
        end
      end
      ST_FILL, ST_STREAM: begin
        // Dropping start aborts the frame even if a pixel is presented this cycle.
        if (!start) begin
          fsm_next = ST_IDLE;
          col_next = '0;
          row_next = '0;
        end else if (din_valid) begin
          accept = 1'b1;
          if (col_last) begin
            col_next = '0;
            row_next = row_reg + CWL'(1);
            if (fsm_reg == ST_FILL && row_reg == CWL'(NB - 1)) begin
              fsm_next = ST_STREAM;
            end
            if (fsm_reg == ST_STREAM && row_last) begin
              fsm_next = ST_IDLE;
              row_next = '0;
            end
          end else begin
            col_next = col_reg + CWL'(1);
          end
        end
      end
      default: begin
        fsm_next = ST_IDLE;
        col_next = '0;
        row_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taps_reg   <= '0;
      tvalid_reg <= 1'b0;
      tcol_reg   <= '0;
      done_reg   <= 1'b0;
    end else begin
      tvalid_reg <= accept && (fsm_reg == ST_STREAM);
      done_reg   <= accept && (fsm_reg == ST_STREAM) && frame_last;
      if (accept) begin
        taps_reg <= slice;
        tcol_reg <= col_reg;
      end
    end
  end

  assign taps   = taps_reg;
  assign tvalid = tvalid_reg;
  assign tcol   = tcol_reg;
  assign done   = done_reg;
  assign busy   = (fsm_reg != ST_IDLE);

endmodule

// File: tb/tb_bnn_window_gen.sv
// Scoreboard bench for bnn_window_gen: a per-pixel image model predicts every slice.
module tb_bnn_window_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        state = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [39:0] taps;
  logic        tvalid;
  logic [4:0]  tcol;
  logic        done;
  logic        busy;

  always #5 clk = ~clk;

  bnn_window_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .state     (state),
    .din       (din),
    .din_valid (din_valid),
    .taps      (taps),
    .tvalid    (tvalid),
    .tcol      (tcol),
    .done      (done),
    .busy      (busy)
  );

  typedef struct {
    int          cyc;
    logic [39:0] taps;
    logic [4:0]  tcol;
    logic        last;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         tv_total = 0;
  int         done_total = 0;
  logic [7:0] img [28][28];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bin(input logic [7:0] v);
`ifdef BNN_WIN_BINARIZE_EN
    return v[7] ? 8'h81 : 8'h01;
`else
    return v;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a slice is due exactly in the cycle recorded when its pixel was driven.
  always @(negedge clk) begin
    if (rstn) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        check("tvalid", 64'(tvalid), 64'(1));
        check("taps", 64'(taps), 64'(mon_e.taps));
        check("tcol", 64'(tcol), 64'(mon_e.tcol));
        check("done", 64'(done), 64'(mon_e.last));
      end else begin
        if (tvalid) check("tvalid_spurious", 64'(tvalid), 64'(0));
        if (done) check("done_spurious", 64'(done), 64'(0));
      end
      if (tvalid) tv_total++;
      if (done) done_total++;
    end
  end

  task automatic run_frame(input int ni, input bit toggle, input bit jitter,
                           input int data_mode, input int abort_at, input int rst_at);
    int          pushed;
    int          tv0;
    int          dn0;
    int          last_p;
    int          r;
    int          c;
    logic [7:0]  v;
    logic [39:0] et;
    pushed = 0;
    tv0 = tv_total;
    dn0 = done_total;
    last_p = ni * ni - 1;
    state = (ni == 12);
    start = 1'b1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_start", 64'(busy), 64'(1));
    for (int p = 0; p <= last_p; p++) begin
      if (p == rst_at) begin
        din_valid = 1'b0;
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        check("rst_taps", 64'(taps), 64'(0));
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tcol", 64'(tcol), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        sb_q.delete();
        start = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        $display("frame ni=%0d reset at pixel %0d, slices seen=%0d", ni, p, tv_total - tv0);
        return;
      end
      r = p / ni;
      c = p % ni;
      case (data_mode)
        0:       v = 8'(p);
        1:       v = 8'h85;
        default: v = 8'h05;
      endcase
      din = v;
      din_valid = 1'b1;
      if (jitter) state = 1'($urandom_range(0, 1));
      if (p == abort_at) start = 1'b0;
      img[r][c] = bin(v);
      if (p != abort_at && r >= 4) begin
        et = '0;
        for (int k = 0; k < 5; k++) et = {et[31:0], img[r-4+k][c]};
        sb_q.push_back('{cyc + 1, et, 5'(c), (p == last_p)});
        pushed++;
      end
      @(posedge clk); #1;
      if (p == last_p || p == abort_at) begin
        check("busy_fall", 64'(busy), 64'(0));
        start = 1'b0;
        break;
      end
      if (toggle) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    din_valid = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_drain", 64'(sb_q.size()), 64'(0));
    check("tvalid_count", 64'(tv_total - tv0), 64'(pushed));
    check("done_count", 64'(done_total - dn0), 64'((abort_at < 0) ? 1 : 0));
    check("busy_idle", 64'(busy), 64'(0));
    $display("frame ni=%0d toggle=%0d abort=%0d data=%0d slices=%0d done=%0d",
             ni, toggle, abort_at, data_mode, tv_total - tv0, done_total - dn0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_taps", 64'(taps), 64'(0));
    check("reset_tvalid", 64'(tvalid), 64'(0));
    check("reset_tcol", 64'(tcol), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;

    // Pixels offered while idle must be ignored.
    din = 8'h55;
    din_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    din_valid = 1'b0;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_tvalid", 64'(tv_total), 64'(0));

    run_frame(12, 1'b0, 1'b0, 0, -1, -1);
    run_frame(28, 1'b0, 1'b0, 0, -1, -1);
    run_frame(12, 1'b1, 1'b1, 0, -1, -1);
    run_frame(12, 1'b0, 1'b0, 0, 70, -1);
    run_frame(12, 1'b0, 1'b0, 0, -1, -1);
    run_frame(12, 1'b0, 1'b0, 0, -1, 90);
    run_frame(12, 1'b0, 1'b0, 0, -1, -1);
    run_frame(12, 1'b0, 1'b0, 0, 143, -1);
    run_frame(12, 1'b0, 1'b0, 0, -1, -1);
    run_frame(12, 1'b0, 1'b0, 1, -1, -1);
    run_frame(12, 1'b0, 1'b0, 2, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_window_gen.md
# bnn_window_gen

Sliding-window tap generator for the BNN convolution datapath. It accepts a row-major 8-bit feature-map pixel stream and buffers the last four rows in line buffers. Each accepted pixel produces one 5-row column slice, packed into the 40-bit `taps` word that the 5x5 binary convolution engine consumes. It serves both conv layers: a 28-wide input map (layer 1) and a 12-wide input map (layer 2), selected by `state`.

## Interface
Parameters:
- `K`, 5: window height; only 5 is supported.
- `DW`, 8: pixel width, sign-magnitude (bit 7 = sign).
- `NI0`, 28: map width/height when `state`=0.
- `NI1`, 12: map width/height when `state`=1.
- `NI_MAX`, 28: line-buffer depth, equal to max(`NI0`,`NI1`).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level enable; high for the whole frame, low returns the block to IDLE.
- `state`, in, 1: layer select, 0→`NI0`, 1→`NI1`; sampled on the IDLE→FILL transition.
- `din`, in, 8: input pixel.
- `din_valid`, in, 1: pixel qualifier; one pixel is accepted per cycle when high in FILL or STREAM.
- `taps`, out, 40: column slice; `[39:32]`=row r-4 (oldest) … `[7:0]`=row r (newest).
- `tvalid`, out, 1: `taps` holds a complete 5-row slice.
- `tcol`, out, 5: column index of the slice in `taps`.
- `done`, out, 1: one-cycle pulse on the last slice of the frame.
- `busy`, out, 1: high in FILL or STREAM.

## Operation
- Counters: `col` runs 0..Ni-1 and wraps; `row` runs 0..Ni-1. Both advance only on an accepted pixel.
- Line buffers: four row buffers, each `NI_MAX`×8, addressed by `col`. On an accepted pixel:
  - Read all four buffers at `col`.
  - Write `din` into buffer 0 and shift each buffer's old value into the next buffer (0→1→2→3), all at the same address.
- Slice formation: `taps` = {buf3[col], buf2[col], buf1[col], buf0[col], din}, captured in the output register.
- FSM:
  - IDLE: counters cleared. Goes to FILL when `start`=1, latching Ni from `state`.
  - FILL: rows 0..3. Slices are not valid. Goes to STREAM after the pixel at (row 3, col Ni-1) is accepted.
  - STREAM: rows 4..Ni-1. Every accepted pixel yields `tvalid`. Goes to IDLE after the pixel at (Ni-1, Ni-1) is accepted, and `done` pulses with that slice.
  - Any state: `start`=0 forces IDLE on the next edge. The frame is aborted and `done` is not pulsed.
- Edge cases:
  - `din_valid` in IDLE is ignored.
  - A change of `state` mid-frame is ignored.
  - If the last pixel is accepted in the same cycle that `start` falls, the abort wins: no `tvalid` and no `done`.
- Per frame, `tvalid` count is (Ni-4)·Ni: 672 for Ni=28, 96 for Ni=12. Column masking for valid convolution outputs is done downstream.
- Line-buffer contents are not reset. They are never exposed, because `tvalid` is gated by `row`.

## Timing
- Latency: 1 cycle from accepted `din` to `taps`/`tvalid`/`tcol`, all registered.
- `tvalid` is high exactly one cycle per accepted STREAM pixel; it is low in cycles without acceptance.
- `done` is coincident with the final `tvalid`. `busy` falls on the same edge.
- A new frame may start as early as the cycle after `done` if `start` has been dropped for at least one cycle; IDLE is mandatory between frames.
- Reset values: `taps`=0, `tvalid`=0, `tcol`=0, `done`=0, `busy`=0, FSM=IDLE, counters=0.
- Asynchronous reset mid-frame clears all of the above immediately.

## Configuration
- `BNN_WIN_BINARIZE_EN` defined:
  - `din` is binarized before buffering: `din[7]`=0 → 8'h01, `din[7]`=1 → 8'h81 (sign-magnitude −1).
  - Applies to both the buffered value and the `taps[7:0]` lane.
- Undefined: `din` passes through unmodified.

## Structure
- Shared package `bnn_pkg` holds:
  - Constants `K`, `DW`, `NI0`, `NI1`, `NI_MAX`.
  - FSM state encoding IDLE/FILL/STREAM.
  - Tap lane offsets (row i at bits [39-8i -: 8]).
- One sub-module, `bnn_line_buffer`: single-row `NI_MAX`×`DW` RAM with a read-before-write port at one address. Four instances are chained.

## Test plan
- Ni=12, `din` = pixel index (0..143), `din_valid` constant high. First `tvalid` follows pixel 48 with `taps`={8'd0,8'd12,8'd24,8'd36,8'd48} and `tcol`=0. Exactly 96 `tvalid`. `done` pulses with the slice for pixel 143, {8'd95,8'd107,8'd119,8'd131,8'd143}.
- Ni=28, `din` = index mod 256. Exactly 672 `tvalid`, the first at pixel 112. `done` once, after pixel 783. `busy` falls with `done`.
- Ni=12 with `din_valid` toggling 1,0,1,0. Slice contents are identical to the first test. `tvalid` appears only in cycles following an acceptance; still 96 `tvalid` total.
- Drop `start` at pixel 70 of an Ni=12 frame. No `done`, FSM returns to IDLE. A restarted frame then yields 96 `tvalid` with correct contents.
- Assert `rstn`=0 mid-STREAM. All outputs read 0 asynchronously. After release, a full frame behaves as in the first test.
- `BNN_WIN_BINARIZE_EN` defined, all `din`=8'h85 in Ni=12. Every valid `taps` = {5{8'h81}}. With `din`=8'h05: {5{8'h01}}.
